// File: rtl/fractal_clk_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// FSM encoding, parameter defaults and a small helper.
package fractal_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD_RST  = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int STATE_W = 2;
  localparam int LLC_W   = 8;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_TICK_DIV           = 4;

  localparam logic [LLC_W-1:0] LLC_MAX = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status bundle between the sequencer and its consumer.
// master = sequencer side, slave = consumer side.
interface pll_reset_sequencer_if;
  import fractal_clk_pkg::*;

  logic               pll_locked;
  logic               rst_out_n;
  logic               ready;
  logic               tick;
  logic [LLC_W-1:0]   lock_loss_count;
  logic [STATE_W-1:0] state;

  modport master (
    input  pll_locked,
    output rst_out_n,
    output ready,
    output tick,
    output lock_loss_count,
    output state
  );

  modport slave (
    output pll_locked,
    input  rst_out_n,
    input  ready,
    input  tick,
    input  lock_loss_count,
    input  state
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// All stages clear to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw input one stage per edge
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // synchronizer register chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the engine in reset until the PLL lock is stable,
// then releases it and produces a divided clock-enable tick.
module pll_reset_sequencer
  import fractal_clk_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int TICK_DIV           = DEF_TICK_DIV
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               pll_locked,
  output logic               rst_out_n,
  output logic               ready,
  output logic               tick,
  output logic [LLC_W-1:0]   lock_loss_count,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);

  logic locked_s;

  pll_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             tick_q, tick_d;
  logic             rst_q, rst_d;
  logic             rdy_q, rdy_d;
  logic [LLC_W-1:0] llc_q, llc_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_in),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    div_d   = '0;
    tick_d  = 1'b0;
    llc_d   = llc_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STAB_LAST) begin
          state_d = HOLD_RST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD_RST: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (llc_q != LLC_MAX) begin
            llc_d = llc_q + LLC_W'(1);
          end
        end else begin
          div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
          tick_d = (div_q == DIV_LAST);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    // outputs track the next state so they align with state_q
    rst_d = (state_d == RUN);
    rdy_d = (state_d == RUN);
  end

  // state, counters and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      rst_q   <= 1'b0;
      rdy_q   <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      llc_q   <= llc_d;
    end
  end

  assign rst_out_n       = rst_q;
  assign ready           = rdy_q;
  assign tick            = tick_q;
  assign lock_loss_count = llc_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer.
// Stimulus queues cycle-tagged expectations; monitor checks.
module tb_pll_reset_sequencer;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4),
    .TICK_DIV           (4)
  ) dut (
    .clk_in          (clk),
    .reset_n         (reset_n),
    .pll_locked      (bus.pll_locked),
    .rst_out_n       (bus.rst_out_n),
    .ready           (bus.ready),
    .tick            (bus.tick),
    .lock_loss_count (bus.lock_loss_count),
    .state           (bus.state)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] st;
    logic       tk;
    logic [7:0] llc;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic want(input int c, input string nm,
                      input logic [1:0] st, input logic tk,
                      input int llc);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.st  = st;
    e.tk  = tk;
    e.llc = 8'(llc);
    sb.push_back(e);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compare every expectation tagged for this cycle
  initial begin
    exp_t e;
    logic er;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_vec++;
        er = (e.st == 2'd3);
        if (e.cyc < cyc) begin
          n_err++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                   e.nm, e.cyc, cyc);
        end else if (bus.rst_out_n !== er || bus.ready !== er ||
                     bus.tick !== e.tk || bus.lock_loss_count !== e.llc ||
                     bus.state !== e.st) begin
          n_err++;
          $display("FAIL %s @%0d: got st=%0d rst=%b rdy=%b tick=%b llc=%0d want st=%0d rst=%b rdy=%b tick=%b llc=%0d",
                   e.nm, cyc, bus.state, bus.rst_out_n, bus.ready,
                   bus.tick, bus.lock_loss_count,
                   e.st, er, er, e.tk, e.llc);
        end
      end
    end
  end

  initial begin
    int c;
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.pll_locked = 1'b0;

    // reset state
    go_to(2);
    want(2, "reset", 2'd0, 1'b0, 0);
    go_to(3);
    reset_n = 1'b1;
    go_to(5);

    // clean lock: release at edge 15, ticks every 4th cycle
    c = cyc;
    want(c + 2,  "seq_wait",    2'd0, 1'b0, 0);
    want(c + 3,  "seq_stab",    2'd1, 1'b0, 0);
    want(c + 10, "seq_stab_end",2'd1, 1'b0, 0);
    want(c + 11, "seq_hold",    2'd2, 1'b0, 0);
    want(c + 14, "seq_hold_end",2'd2, 1'b0, 0);
    want(c + 15, "seq_run",     2'd3, 1'b0, 0);
    want(c + 18, "tick_pre",    2'd3, 1'b0, 0);
    want(c + 19, "tick_first",  2'd3, 1'b1, 0);
    want(c + 20, "tick_post",   2'd3, 1'b0, 0);
    want(c + 23, "tick_second", 2'd3, 1'b1, 0);
    bus.pll_locked = 1'b1;
    go_to(c + 24);

    // one-cycle lock glitch in RUN, then full relock
    c = cyc;
    want(c + 2,  "glitch_run",   2'd3, 1'b0, 0);
    want(c + 3,  "glitch_drop",  2'd0, 1'b0, 1);
    want(c + 4,  "glitch_stab",  2'd1, 1'b0, 1);
    want(c + 15, "relock_hold",  2'd2, 1'b0, 1);
    want(c + 16, "relock_run",   2'd3, 1'b0, 1);
    want(c + 20, "relock_tick",  2'd3, 1'b1, 1);
    bus.pll_locked = 1'b0;
    go_to(c + 1);
    bus.pll_locked = 1'b1;
    go_to(c + 21);

    // drop lock, then a 5-cycle pulse that never qualifies
    c = cyc;
    want(c + 3,  "pulse_drop",  2'd0, 1'b0, 2);
    want(c + 8,  "pulse_stab",  2'd1, 1'b0, 2);
    want(c + 12, "pulse_stab2", 2'd1, 1'b0, 2);
    want(c + 13, "pulse_back",  2'd0, 1'b0, 2);
    want(c + 20, "pulse_idle",  2'd0, 1'b0, 2);
    bus.pll_locked = 1'b0;
    go_to(c + 5);
    bus.pll_locked = 1'b1;
    go_to(c + 10);
    bus.pll_locked = 1'b0;
    go_to(c + 21);

    // lock loss on the STABILIZE terminal-count edge
    c = cyc;
    want(c + 10, "tc_stab",  2'd1, 1'b0, 2);
    want(c + 11, "tc_prio",  2'd0, 1'b0, 2);
    bus.pll_locked = 1'b1;
    go_to(c + 8);
    bus.pll_locked = 1'b0;
    go_to(c + 12);

    // async reset mid-HOLD_RST and mid-RUN
    c = cyc;
    want(c + 11, "rh_hold",     2'd2, 1'b0, 2);
    want(c + 12, "rh_async",    2'd0, 1'b0, 0);
    want(c + 13, "rh_held",     2'd0, 1'b0, 0);
    want(c + 16, "rh_stab",     2'd1, 1'b0, 0);
    want(c + 27, "rh_hold2",    2'd2, 1'b0, 0);
    want(c + 28, "rh_run",      2'd3, 1'b0, 0);
    want(c + 30, "rr_async",    2'd0, 1'b0, 0);
    want(c + 31, "rr_released", 2'd0, 1'b0, 0);
    bus.pll_locked = 1'b1;
    go_to(c + 12);
    reset_n = 1'b0;
    go_to(c + 13);
    reset_n = 1'b1;
    go_to(c + 30);
    reset_n = 1'b0;
    bus.pll_locked = 1'b0;
    go_to(c + 31);
    reset_n = 1'b1;
    go_to(c + 35);

    // 300 lock losses: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      want(c + 15, "sat_run",  2'd3, 1'b0, (i < 255) ? i : 255);
      want(c + 18, "sat_loss", 2'd0, 1'b0, (i + 1 < 255) ? i + 1 : 255);
      bus.pll_locked = 1'b1;
      go_to(c + 15);
      bus.pll_locked = 1'b0;
      go_to(c + 18);
    end

    go_to(cyc + 2);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
